// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing popcount accumulator.
// Build option: SC_BIPOLAR_EN selects bipolar (XNOR, signed) arithmetic.
package sc_pkg;

    typedef enum logic [1:0] {
        ACC,
        FLUSH,
        DONE
    } state_t;

    // Width needed to hold a popcount of 0..bitstream inclusive.
    function automatic int pc_width(input int bitstream);
        return $clog2(bitstream) + 1;
    endfunction

endpackage

// File: rtl/sc_popcount.sv
// Combinational popcount of a bitstream, built as a balanced binary adder tree.
module sc_popcount
    import sc_pkg::*;
#(
    parameter int BITSTREAM = 64,
    parameter int PC_W      = pc_width(BITSTREAM)
) (
    input  logic [BITSTREAM-1:0] bits,
    output logic [PC_W-1:0]      count
);

    // Leaves are padded up to a power of two so every tree level is full.
    localparam int unsigned LEAVES = 2 ** $clog2(BITSTREAM);

    // Heap-ordered tree: node j sums children 2j+1 and 2j+2; node 0 is the root.
    function automatic logic [PC_W-1:0] tree_sum(input logic [LEAVES-1:0] v);
        logic [PC_W-1:0] node [2*LEAVES-1];
        int unsigned     j;
        for (int unsigned i = 0; i < LEAVES; i++) begin
            node[LEAVES-1+i] = PC_W'(v[i]);
        end
        for (int unsigned k = 0; k < LEAVES - 1; k++) begin
            j       = LEAVES - 2 - k;
            node[j] = node[2*j+1] + node[2*j+2];
        end
        return node[0];
    endfunction

    logic [LEAVES-1:0] padded;

    // Zero-extend the stream to the tree width and reduce it.
    always_comb begin
        padded = LEAVES'(bits);
        count  = tree_sum(padded);
    end

endmodule

// File: rtl/sc_popcount_acc.sv
// Stochastic dot-product accumulator: per accepted beat, multiplies weight and
// activation bitstreams, popcounts the product and accumulates it with
// saturation; the final sum is held on a valid/ready output until consumed.
// Build option: SC_BIPOLAR_EN selects XNOR product and signed accumulation.
module sc_popcount_acc
    import sc_pkg::*;
#(
    parameter int BITSTREAM = 64,
    parameter int ACC_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 i_last,
    input  logic [BITSTREAM-1:0] i_w_bits,
    input  logic [BITSTREAM-1:0] i_x_bits,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [ACC_W-1:0]     o_sum,
    output logic                 o_ovf
);

    localparam int PC_W = pc_width(BITSTREAM);

    state_t               state;
    state_t               state_next;
    logic                 accept;
    logic                 handshake;
    logic [BITSTREAM-1:0] product;
    logic [PC_W-1:0]      pc;
    logic [PC_W-1:0]      pc_q;
    logic                 v_q;
    logic                 last_q;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_next;
    logic                 ovf;
    logic                 sat;
    logic [ACC_W:0]       sum_ext;

    assign accept    = i_valid & i_ready;
    assign handshake = o_valid & o_ready;
    assign o_sum     = acc;
    assign o_ovf     = ovf;

`ifdef SC_BIPOLAR_EN
    logic [PC_W:0] contrib;

    // Bipolar: XNOR product, contribution 2*pc - BITSTREAM, signed saturation.
    always_comb begin
        product  = ~(i_w_bits ^ i_x_bits);
        contrib  = {pc_q, 1'b0} - (PC_W+1)'(BITSTREAM);
        sum_ext  = {acc[ACC_W-1], acc} + {{(ACC_W-PC_W){contrib[PC_W]}}, contrib};
        sat      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        acc_next = sum_ext[ACC_W-1:0];
        if (sat) begin
            acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    // Unipolar: AND product, unsigned add clamped at all-ones.
    always_comb begin
        product  = i_w_bits & i_x_bits;
        sum_ext  = {1'b0, acc} + {{(ACC_W+1-PC_W){1'b0}}, pc_q};
        sat      = sum_ext[ACC_W];
        acc_next = sat ? '1 : sum_ext[ACC_W-1:0];
    end
`endif

    sc_popcount #(
        .BITSTREAM (BITSTREAM),
        .PC_W      (PC_W)
    ) u_popcount (
        .bits  (product),
        .count (pc)
    );

    // Stage 1: register the popcount of each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            v_q    <= 1'b0;
            last_q <= 1'b0;
        end else begin
            v_q <= accept;
            if (accept) begin
                pc_q   <= pc;
                last_q <= i_last;
            end
        end
    end

    // Stage 2: saturating accumulate; cleared when the result is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (handshake) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (v_q) begin
            acc <= acc_next;
            ovf <= ovf | sat;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_next = state;
        i_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            ACC: begin
                i_ready = 1'b1;
                if (i_valid && i_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (v_q && last_q) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

endmodule

// File: tb/tb_sc_popcount_acc.sv
// Scoreboard bench for sc_popcount_acc: a 16-bit accumulator instance and an
// 8-bit instance for saturation. Expected values follow SC_BIPOLAR_EN.
module tb_sc_popcount_acc;

`ifdef SC_BIPOLAR_EN
    localparam bit BIP = 1'b1;
`else
    localparam bit BIP = 1'b0;
`endif

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] w_bits = '0;
    logic [63:0] x_bits = '0;
    logic        last = 1'b0;
    logic        valid16 = 1'b0;
    logic        valid8 = 1'b0;
    logic        o_ready = 1'b1;

    logic        rdy16, rdy8, ov16, ov8, ovf16, ovf8;
    logic [15:0] sum16;
    logic [7:0]  sum8;

    always #5 clk = ~clk;

    sc_popcount_acc #(.BITSTREAM(64), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .i_valid(valid16), .i_ready(rdy16), .i_last(last),
        .i_w_bits(w_bits), .i_x_bits(x_bits), .o_valid(ov16), .o_ready(o_ready),
        .o_sum(sum16), .o_ovf(ovf16)
    );

    sc_popcount_acc #(.BITSTREAM(64), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .i_valid(valid8), .i_ready(rdy8), .i_last(last),
        .i_w_bits(w_bits), .i_x_bits(x_bits), .o_valid(ov8), .o_ready(o_ready),
        .o_sum(sum8), .o_ovf(ovf8)
    );

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [15:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pop and compare whenever a result is consumed.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov16 && o_ready) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result16 actual=%0h required=none", sum16);
            end else begin
                e = q16.pop_front();
                check("sum16", 32'(sum16), 32'(e.sum));
                check("ovf16", 32'(ovf16), 32'(e.ovf));
            end
        end
        if (!rst && ov8 && o_ready) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result8 actual=%0h required=none", sum8);
            end else begin
                e = q8.pop_front();
                check("sum8", 32'(sum8), 32'(e.sum));
                check("ovf8", 32'(ovf8), 32'(e.ovf));
            end
        end
    end

    // Drive one beat from a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [63:0] w, input logic [63:0] x, input logic l, input bit to8);
        int n;
        w_bits = w;
        x_bits = x;
        last   = l;
        if (to8) valid8 = 1'b1;
        else     valid16 = 1'b1;
        n = 0;
        while (!(to8 ? rdy8 : rdy16) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(negedge clk);
        valid8  = 1'b0;
        valid16 = 1'b0;
        last    = 1'b0;
    endtask

    // Counts negedges from the last-beat acceptance until o_valid (bounded).
    task automatic wait_valid16(output int lat);
        lat = 1;
        while (!ov16 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid16", 32'(ov16), 0);
        check("rst_ready16", 32'(rdy16), 1);
        check("rst_sum16", 32'(sum16), 0);
        check("rst_ovf16", 32'(ovf16), 0);
        check("rst_valid8", 32'(ov8), 0);
        check("rst_ready8", 32'(rdy8), 1);
        rst = 1'b0;

        // Single-beat dot product
        q16.push_back(mk(BIP ? 16'd0 : 16'd32, 1'b0));
        send(ONES, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
        wait_valid16(lat);
        check("latency_single", 32'(lat), 2);
        @(negedge clk);
        check("ready_after_hs", 32'(rdy16), 1);

        // Four beats held under backpressure; ignored beats while not ready
        @(posedge clk);
        #1 o_ready = 1'b0;
        @(negedge clk);
        q16.push_back(mk(16'd256, 1'b0));
        for (int i = 0; i < 4; i++) send(ONES, ONES, i == 3, 1'b0);
        wait_valid16(lat);
        check("latency_four", 32'(lat), 2);
        for (int i = 0; i < 10; i++) begin
            check("hold_sum", 32'(sum16), 256);
            check("hold_valid", 32'(ov16), 1);
            check("hold_ready", 32'(rdy16), 0);
            w_bits  = ONES;
            x_bits  = ONES;
            last    = 1'b1;
            valid16 = 1'b1;
            @(negedge clk);
        end
        valid16 = 1'b0;
        last    = 1'b0;
        @(posedge clk);
        #1 o_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_bp", 32'(rdy16), 1);

        // Next dot product starts from zero
        q16.push_back(mk(BIP ? 16'd64 : 16'd8, 1'b0));
        send(64'hFF, 64'hFF, 1'b1, 1'b0);
        wait_valid16(lat);
        check("latency_fresh", 32'(lat), 2);
        @(negedge clk);

        // Saturation on the 8-bit accumulator
        q8.push_back(mk(BIP ? 16'd127 : 16'd255, 1'b1));
        for (int i = 0; i < 5; i++) send(ONES, ONES, i == 4, 1'b1);
        n = 0;
        while (!ov8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("valid8_seen", 32'(ov8), 1);
        @(negedge clk);

        // All-zero x: unipolar adds 0, bipolar adds -64 per beat
        q16.push_back(mk(BIP ? 16'hFF80 : 16'h0000, 1'b0));
        send(ONES, 64'h0, 1'b0, 1'b0);
        send(ONES, 64'h0, 1'b1, 1'b0);
        wait_valid16(lat);
        check("latency_zero", 32'(lat), 2);
        @(negedge clk);

        // Reset mid-accumulation discards the partial sum
        send(ONES, ONES, 1'b0, 1'b0);
        send(ONES, ONES, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("no_valid_after_rst", 32'(ov16), 0);
            @(negedge clk);
        end
        q16.push_back(mk(BIP ? 16'd64 : 16'd8, 1'b0));
        send(64'hFF, 64'hFF, 1'b1, 1'b0);
        wait_valid16(lat);
        check("latency_after_rst", 32'(lat), 2);
        repeat (3) @(negedge clk);

        check("q16_drained", 32'(q16.size()), 0);
        check("q8_drained", 32'(q8.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
